// File: rtl/fp32_pkg.sv
// Shared fp32 definitions: field layout, constants and divider state encoding.
package fp32_pkg;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    // Quotient bits developed per division: 24 significand + 1 normalisation + 1 guard.
    localparam int          QBITS    = 26;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } div_flags_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        NORM,
        FIN
    } div_state_t;

endpackage

// File: rtl/adder_10bit.sv
// 10-bit two's-complement adder with carry-in; used for all exponent arithmetic.
module adder_10bit (
    input  logic [9:0] a_i,
    input  logic [9:0] b_i,
    input  logic       cin_i,
    output logic [9:0] sum_o
);

    assign sum_o = a_i + b_i + {9'd0, cin_i};

endmodule

// File: rtl/adder_24bit.sv
// 24-bit adder with carry-in and carry-out; used for the rounding increment.
module adder_24bit (
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  logic        cin_i,
    output logic [23:0] sum_o,
    output logic        cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {24'd0, cin_i};

endmodule

// File: rtl/sub_25bit.sv
// 25-bit ripple-carry subtractor: a - b as a + ~b + 1; carry-out 1 means a >= b.
module sub_25bit (
    input  logic [24:0] a_i,
    input  logic [24:0] b_i,
    output logic [24:0] diff_o,
    output logic        no_borrow_o
);

    logic carry;
    logic b_n;

    // Full-adder chain, LSB first, carry-in 1 with the subtrahend inverted.
    always_comb begin
        // NOTE: blocking assignments in combinational logic so 'carry' ripples
        // bit by bit within this single evaluation of the loop.
        carry  = 1'b1;
        b_n    = 1'b0;
        diff_o = '0;
        for (int i = 0; i < 25; i++) begin
            b_n       = ~b_i[i];
            diff_o[i] = a_i[i] ^ b_n ^ carry;
            carry     = (a_i[i] & b_n) | (carry & (a_i[i] ^ b_n));
        end
        no_borrow_o = carry;
    end

endmodule

// File: rtl/fp32_div_seq.sv
// Iterative fp32 divider: restoring shift-subtract, one quotient bit per cycle,
// round-to-nearest-even, denormals flushed to zero, start/busy/done handshake.
import fp32_pkg::*;

module fp32_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);

    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [23:0] mb_q, mb_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;
    logic [31:0] result_q, result_d;
    div_flags_t  flags_q, flags_d;

    fp32_t a_f, b_f;
    assign a_f = a;
    assign b_f = b;

    // ------------------------------------------------------------------
    // Operand classification and special-case result
    // ------------------------------------------------------------------
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_ab;
    logic        spec_hit;
    logic [31:0] spec_res;
    div_flags_t  spec_flags;

    assign a_zero  = (a_f.exp == 8'h00);
    assign b_zero  = (b_f.exp == 8'h00);
    assign a_inf   = (a_f.exp == 8'hFF) && (a_f.frac == '0);
    assign b_inf   = (b_f.exp == 8'hFF) && (b_f.frac == '0);
    assign a_nan   = (a_f.exp == 8'hFF) && (a_f.frac != '0);
    assign b_nan   = (b_f.exp == 8'hFF) && (b_f.frac != '0);
    assign sign_ab = a_f.sign ^ b_f.sign;

    // Priority-ordered special-operand result; spec_hit bypasses the iteration.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        spec_hit   = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res           = QNAN;
            spec_flags.invalid = 1'b1;
        end else if (a_inf) begin
            spec_res = POS_INF | {sign_ab, 31'd0};
        end else if (b_inf) begin
            spec_res = {sign_ab, 31'd0};
        end else if (b_zero) begin
            spec_res               = POS_INF | {sign_ab, 31'd0};
            spec_flags.div_by_zero = 1'b1;
        end else if (a_zero) begin
            spec_res = {sign_ab, 31'd0};
        end
    end

    // Biased quotient exponent ea - eb + 127, 10-bit signed.
    logic [9:0] exp_diff, exp_init;

    adder_10bit u_exp_diff (
        .a_i   ({2'b00, a_f.exp}),
        .b_i   (~{2'b00, b_f.exp}),
        .cin_i (1'b1),
        .sum_o (exp_diff)
    );

    adder_10bit u_exp_bias (
        .a_i   (exp_diff),
        .b_i   (10'(EXP_BIAS)),
        .cin_i (1'b0),
        .sum_o (exp_init)
    );

    // ------------------------------------------------------------------
    // Trial subtraction for the restoring loop
    // ------------------------------------------------------------------
    logic [24:0] trial;
    logic        no_borrow;

    sub_25bit u_trial (
        .a_i         (rem_q),
        .b_i         ({1'b0, mb_q}),
        .diff_o      (trial),
        .no_borrow_o (no_borrow)
    );

    // ------------------------------------------------------------------
    // Normalisation and rounding of the developed quotient
    // ------------------------------------------------------------------
    logic        q_top, guard, sticky, round_up, sig_carry;
    logic [23:0] sig_pre, sig_rnd;
    logic [9:0]  exp_adj, exp_fin;
    logic [31:0] norm_res;
    div_flags_t  norm_flags;

    // Pick the 24 significand bits, guard and sticky depending on the leading bit.
    always_comb begin
        q_top    = quo_q[25];
        sig_pre  = q_top ? quo_q[25:2] : quo_q[24:1];
        guard    = q_top ? quo_q[1] : quo_q[0];
        sticky   = (q_top & quo_q[0]) | (|rem_q);
        round_up = guard & (sticky | sig_pre[0]);
        exp_adj  = q_top ? 10'd0 : 10'h3FF;
    end

    adder_24bit u_round (
        .a_i    (sig_pre),
        .b_i    (24'd0),
        .cin_i  (round_up),
        .sum_o  (sig_rnd),
        .cout_o (sig_carry)
    );

    // Exponent minus one when q[25]=0, plus one when rounding carries out.
    adder_10bit u_exp_norm (
        .a_i   (exp_q),
        .b_i   (exp_adj),
        .cin_i (sig_carry),
        .sum_o (exp_fin)
    );

    // Range check; a rounding carry leaves sig_rnd[22:0] all zero, i.e. 1.0.
    always_comb begin
        norm_res   = {sign_q, exp_fin[7:0], sig_rnd[22:0]};
        norm_flags = '0;
        if (!exp_fin[9] && (exp_fin >= 10'd255)) begin
            norm_res            = POS_INF | {sign_q, 31'd0};
            norm_flags.overflow = 1'b1;
        end else if (exp_fin[9] || (exp_fin == 10'd0)) begin
            norm_res             = {sign_q, 31'd0};
            norm_flags.underflow = 1'b1;
        end
    end

    // Bits that are provably zero or implied by normalisation.
    logic unused_bits;
    assign unused_bits = ^{sig_rnd[23], trial[24]};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = spec_hit ? FIN : ITER;
            ITER:    if (cnt_q == CNT_LAST) state_d = NORM;
            NORM:    state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FIN);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Datapath next-state: capture on acceptance, iterate, then register the result.
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mb_d     = mb_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    flags_d = '0;
                    sign_d  = sign_ab;
                    exp_d   = exp_init;
                    mb_d    = {1'b1, b_f.frac};
                    rem_d   = {2'b01, a_f.frac};
                    quo_d   = '0;
                    cnt_d   = '0;
                    if (spec_hit) begin
                        result_d = spec_res;
                        flags_d  = spec_flags;
                    end
                end
            end
            ITER: begin
                rem_d = no_borrow ? {trial[23:0], 1'b0} : {rem_q[23:0], 1'b0};
                quo_d = {quo_q[24:0], no_borrow};
                cnt_d = cnt_q + 5'd1;
            end
            NORM: begin
                result_d = norm_res;
                flags_d  = norm_flags;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            mb_q     <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mb_q     <= mb_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result      = result_q;
    assign invalid     = flags_q.invalid;
    assign div_by_zero = flags_q.div_by_zero;
    assign overflow    = flags_q.overflow;
    assign underflow   = flags_q.underflow;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: directed cases, handshake/reset, random ops
// compared against an integer-arithmetic reference of the division rules.
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;
    logic        invalid, div_by_zero, overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp32_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .invalid     (invalid),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, invalid, div_by_zero, overflow, underflow};
    endfunction

    // Reference: exact integer quotient of the significands, then RNE and range rules.
    // Flags packed as {invalid, div_by_zero, overflow, underflow}.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [3:0] f,
                                    output bit sp);
        logic            s, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        longint unsigned num, den, q, rem, sig;
        bit              g, st;
        int              e;
        s      = x[31] ^ y[31];
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        f  = 4'b0000;
        sp = 1'b1;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            r = 32'h7FC00000; f = 4'b1000;
        end else if (x_inf) begin
            r = {s, 8'hFF, 23'd0};
        end else if (y_inf) begin
            r = {s, 31'd0};
        end else if (y_zero) begin
            r = {s, 8'hFF, 23'd0}; f = 4'b0100;
        end else if (x_zero) begin
            r = {s, 31'd0};
        end else begin
            sp  = 1'b0;
            num = 64'({1'b1, x[22:0]}) << 25;
            den = 64'({1'b1, y[22:0]});
            q   = num / den;
            rem = num % den;
            e   = int'(x[30:23]) - int'(y[30:23]) + 127;
            if (q[25]) begin
                sig = q >> 2; g = q[1]; st = q[0] || (rem != 0);
            end else begin
                sig = q >> 1; g = q[0]; st = (rem != 0); e = e - 1;
            end
            if (g && (st || sig[0])) sig = sig + 1;
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23; e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0}; f = 4'b0010;
            end else if (e <= 0) begin
                r = {s, 31'd0}; f = 4'b0001;
            end else begin
                r = {s, e[7:0], sig[22:0]};
            end
        end
    endfunction

    // Issue one operation from an idle, post-edge point; returns one cycle after done.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input bit poke_start);
        logic [31:0] er;
        logic [3:0]  ef;
        bit          sp;
        int          lat;
        int          busy_bad;
        ref_div(op_a, op_b, er, ef, sp);
        a = op_a; b = op_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 1; busy_bad = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_bad++;
            if (poke_start && lat == 5) begin
                start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        if (!busy) busy_bad++;
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, lat, sp ? 32'd1 : 32'd28);
        check({tag, " result"}, result, er);
        check({tag, " flags"}, flags_now(), {28'd0, ef});
        check({tag, " busy"}, busy_bad, 32'd0);
        @(posedge clk); #1;
        check({tag, " after done"}, {30'd0, done, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(9))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[22:0]  = 23'd0;
            3: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            4, 5: v[30:23] = 8'($urandom_range(100, 154));
            default: ;
        endcase
        return v;
    endfunction

    logic [31:0] dir_a [9] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                               32'h00000000, 32'h7F800000, 32'h7F7FFFFF, 32'h00800000,
                               32'h7FC00001};
    logic [31:0] dir_b [9] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000,
                               32'h00000000, 32'h7F800000, 32'h3E800000, 32'h40000000,
                               32'h3F800000};

    initial begin
        int seen;
        // Reset state
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", flags_now(), 32'd0);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases, including literal expectations for key vectors
        for (int i = 0; i < 9; i++) run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i], 1'b0);
        run_op("six_by_two", 32'h40C00000, 32'h40000000, 1'b0);
        check("six_by_two literal", result, 32'h40400000);
        run_op("one_by_three", 32'h3F800000, 32'h40400000, 1'b0);
        check("one_by_three literal", result, 32'h3EAAAAAB);

        // start while busy is ignored
        run_op("busy_start", 32'h40C00000, 32'h40000000, 1'b1);
        check("busy_start literal", result, 32'h40400000);

        // Asynchronous reset mid-operation
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        check("midreset flags", flags_now(), 32'd0);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("midreset quiet", seen, 32'd0);
        run_op("after_reset", 32'h40C00000, 32'h40000000, 1'b0);
        check("after_reset literal", result, 32'h40400000);

        // Randomized operations against the reference
        for (int i = 0; i < 150; i++) run_op($sformatf("rand%0d", i), rand_fp(), rand_fp(), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
Iterative IEEE-754 single-precision divider, the inverse of the datapath's FP32 multiplier. It computes a/b with a restoring shift-subtract loop, one quotient bit per cycle. Trial subtraction is done by a ripple-carry FA chain. It sits beside the multiplier in the arithmetic unit and uses a start/busy/done handshake.

Parameters:
QBITS, 26, quotient bits developed: 24 significand + 1 normalisation + 1 guard. Fixed for fp32; not overridden.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
a  input  32  dividend, fp32
b  input  32  divisor, fp32
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse, result/flags valid
result  output  32  quotient, held until the next acceptance
invalid  output  1  NaN operand, 0/0 or inf/inf
div_by_zero  output  1  finite nonzero / zero
overflow  output  1  result rounded to infinity
underflow  output  1  result flushed to zero

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset, asserted at any time including mid-operation:
  - state=IDLE.
  - busy, done, result and all flags = 0.
  - In-flight operation is discarded.
- Acceptance: start=1 and busy=0 at edge T.
  - a and b are captured.
  - Flags are cleared.
  - start while busy=1 is ignored; no queueing.
- States: IDLE, ITER, NORM, FIN.
- IDLE + start, special operand:
  - Go to FIN.
  - done=1 at T+1, busy high for that one cycle.
- IDLE + start, normal operand:
  - Go to ITER with cnt=0 and R = {1'b0, ma}, where ma and mb carry the hidden 1.
  - Sign sa^sb and exponent ea-eb+127 are latched. The exponent is 10-bit signed.
- ITER: one cycle per bit, for QBITS cycles (T+1..T+26).
  - Trial D = R - {1'b0, mb}.
  - If no borrow: q bit = 1 and R = D<<1. Otherwise q bit = 0 and R = R<<1.
  - q shifts left; MSB first.
  - After cnt = QBITS-1, go to NORM.
- NORM (T+27), normalisation:
  - If q[25]=1: significand q[25:2], guard q[1], sticky q[0] | (R!=0). Exponent unchanged.
  - Otherwise: significand q[24:1], guard q[0], sticky R!=0. Exponent -1.
- NORM, rounding: round-to-nearest-even. Increment when guard & (sticky | lsb).
  - A carry out of 24 bits gives significand 1.0 and exponent +1.
- NORM, range check:
  - exp >= 255: ±inf (0x7F800000 | sign), overflow=1.
  - exp <= 0: ±0, underflow=1.
- FIN (T+28 for normal operands):
  - result and flags registered; done=1 for one cycle; busy=0 next.
  - Back to IDLE, where a new start can be accepted.
- Denormal inputs (exp=0) are treated as zero. Denormal outputs are never produced.
- Specials, in priority order:
  1. Any NaN, 0/0 or inf/inf: 0x7FC00000, invalid=1, sign 0.
  2. inf/finite: ±inf.
  3. finite/inf: ±0.
  4. nonzero/0: ±inf, div_by_zero=1.
  5. 0/nonzero: ±0.
- Latency: normal 28 cycles accept-to-done; special 1 cycle.
- Throughput: one operation per 29 cycles (normal) or 2 cycles (special).

Decomposition:
- Shared package fp32_pkg:
  - EXP_BIAS=127, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - Field-extract typedef (sign, exp[7:0], frac[22:0]).
  - div_state_t enum {IDLE, ITER, NORM, FIN}.
- Sub-module sub_25bit:
  - Ripple-carry chain of FA cells with carry-in 1 and in2 inverted.
  - Carry-out 1 means no borrow, i.e. R >= divisor.
- Significand increment and exponent arithmetic reuse adder_24bit and adder_10bit.

Test Plan:
- 6.0/2.0 (a=0x40C00000, b=0x40000000): done at T+28, result 0x40400000, all flags 0. busy high T+1..T+28.
- 1.0/3.0 (0x3F800000/0x40400000): result 0x3EAAAAAB (RNE round-up). Also -1.0/2.0 (0xBF800000/0x40000000): result 0xBF000000.
- Specials:
  - 0x3F800000/0x00000000: result 0x7F800000, div_by_zero=1, done at T+1.
  - 0/0: result 0x7FC00000, invalid=1.
  - 0x7F800000/0x7F800000: result 0x7FC00000, invalid=1.
- Range:
  - 0x7F7FFFFF/0x3E800000: result 0x7F800000, overflow=1.
  - 0x00800000/0x40000000: result 0x00000000, underflow=1.
- Handshake and reset:
  - start pulsed again at T+5 with other operands: ignored, first result unchanged.
  - rst_n low at T+10: busy=0, done=0, result=0 immediately, no done pulse follows.
  - A following 6.0/2.0 then completes normally with 0x40400000.
